bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly downstream of the calculator ALU stage.
- Takes the 9/10-bit result plus a sign flag and produces one BCD nibble per seven-segment digit for the dec_to_hex decoders.
- Replaces the combinational /10 and %10 chains with a small iterative datapath.

---
 rtl/bin_to_bcd_seq.sv | 119 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional build macro BIN_TO_BCD_LEADING_BLANK_EN blanks leading zero digits with 4'hF.
module bin_to_bcd_seq #(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  neg_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [IN_W-1:0]   shreg;
    logic [BCD_W-1:0]  scratch;
    logic [BCD_W-1:0]  adj;
    logic [CNT_W-1:0]  cnt;
    logic              sticky;
    logic              sign;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Saturate to all nines on overflow; optionally blank leading zeros of an in-range result.
    function automatic logic [BCD_W-1:0] finalize(input logic [BCD_W-1:0] d, input logic sat);
        logic [BCD_W-1:0] r;
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
        logic lead;
`endif
        r = sat ? {DIGITS{4'h9}} : d;
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
        lead = !sat;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (r[4*i +: 4] == 4'h0))
                r[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
`endif
        return r;
    endfunction

    always_comb begin
        adj = add3(scratch);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            sign    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            neg_out <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg   <= bin_in;
                        sign    <= neg_in;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A bit leaving the top digit means the value needs more than DIGITS digits.
                    scratch <= {adj[BCD_W-2:0], shreg[IN_W-1]};
                    shreg   <= {shreg[IN_W-2:0], 1'b0};
                    sticky  <= sticky | adj[BCD_W-1];
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT)
                        state <= DONE;
                end
                DONE: begin
                    bcd_out <= finalize(scratch, sticky);
                    ovf     <= sticky;
                    neg_out <= sign;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: 4-digit and 2-digit instances driven in lockstep, checked against a decimal model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  bin_in;
    logic        neg_in;
    logic        busy, done, neg_out, ovf;
    logic [15:0] bcd_out;
    logic        busy2, done2, neg2, ovf2;
    logic [7:0]  bcd2;

    int checks = 0;
    int errors = 0;

    logic [15:0] last_e4, last_e2;
    logic        last_o4, last_o2, last_neg;

    bin_to_bcd_seq #(.IN_W(10), .DIGITS(4)) dut (
        .CLOCK_50(clk), .RESET(rst), .start(start), .bin_in(bin_in), .neg_in(neg_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .neg_out(neg_out), .ovf(ovf)
    );

    bin_to_bcd_seq #(.IN_W(10), .DIGITS(2)) dut2 (
        .CLOCK_50(clk), .RESET(rst), .start(start), .bin_in(bin_in), .neg_in(neg_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .neg_out(neg2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Decimal digits of v, saturated to nines when v needs more than nd digits.
    function automatic logic [15:0] model(input int v, input int nd, output logic o);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        o = (v >= p);
        if (o)
            for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
        p = 1;
        for (int i = 0; i < nd; i++) begin
            if (!o && i > 0 && v < p) r[4*i +: 4] = 4'hF;
            p = p * 10;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic convert(input logic [9:0] b, input logic n, input bit poke);
        int lat;
        int bcnt;
        start  = 1'b1;
        bin_in = b;
        neg_in = n;
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 10'($urandom);
        neg_in = 1'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (poke && (lat == 3 || lat == 7)) begin
                start  = 1'b1;
                bin_in = 10'd500;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        last_e4  = model(int'(b), 4, last_o4);
        last_e2  = model(int'(b), 2, last_o2);
        last_neg = n;
        check("latency", lat, 11);
        check("busy_len", bcnt, 11);
        check("done2_sync", done2, 1'b1);
        check("bcd4", bcd_out, last_e4);
        check("ovf4", ovf, last_o4);
        check("neg4", neg_out, n);
        check("bcd2", {8'h00, bcd2}, last_e2);
        check("ovf2", ovf2, last_o2);
        check("neg2", neg2, n);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b0);
        check("done2_pulse", done2, 1'b0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            check("hold_done", done, 1'b0);
            check("hold_bcd", bcd_out, last_e4);
            check("hold_bcd2", {8'h00, bcd2}, last_e2);
            check("hold_ovf", {ovf, ovf2}, {last_o4, last_o2});
            check("hold_neg", neg_out, last_neg);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int seen;
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        neg_in = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {busy, busy2}, 2'b00);
        check("rst_done", {done, done2}, 2'b00);
        check("rst_bcd", {bcd_out, bcd2}, 24'h0);
        check("rst_neg_ovf", {neg_out, ovf, neg2, ovf2}, 4'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        convert(10'd1023, 1'b0, 1'b0);
        hold(3);
        convert(10'd0, 1'b0, 1'b0);
        hold(5);
        convert(10'd999, 1'b1, 1'b0);
        hold(2);
        convert(10'd37, 1'b0, 1'b1);
        hold(15);

        // Asynchronous reset partway through a conversion.
        start  = 1'b1;
        bin_in = 10'd512;
        neg_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("amid_busy", {busy, busy2}, 2'b00);
        check("amid_done", {done, done2}, 2'b00);
        check("amid_bcd", {bcd_out, bcd2}, 24'h0);
        check("amid_neg_ovf", {neg_out, ovf, neg2, ovf2}, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || done2 || busy) seen++;
            @(posedge clk); #1;
        end
        check("no_done_after_rst", seen, 0);

        convert(10'd5, 1'b0, 1'b0);
        convert(10'd150, 1'b0, 1'b0);
        convert(10'd42, 1'b0, 1'b0);
        convert(10'd7, 1'b0, 1'b0);
        convert(10'd305, 1'b1, 1'b0);
        convert(10'd99, 1'b0, 1'b0);
        convert(10'd100, 1'b0, 1'b0);
        hold(2);

        for (int k = 0; k < 24; k++) begin
            convert(10'($urandom), 1'($urandom), 1'($urandom));
            hold(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
